// File: rtl/fir_pkg.sv
// Shared constants for the symmetric FIR MAC sequencer: default geometry,
// beat count, pipeline depth and the sequencer state encoding.
package fir_pkg;

    localparam int TAPS_DEF  = 73;
    localparam int AW_DEF    = 7;
    localparam int NX_DEF    = 100;
    localparam int NSAMP_DEF = 172;
    localparam int YAW_DEF   = 8;

    // Cycles between sum_en and acc_en: one for the ROM/pre-adder, one for the multiplier.
    localparam int PIPE_D = 2;

    function automatic int nb_of(input int taps);
        return (taps + 1) / 2;
    endfunction

    localparam int NB = nb_of(TAPS_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        RED   = 3'd4,
        WRT   = 3'd5,
        FIN   = 3'd6
    } fir_state_t;

endpackage

// File: rtl/fir_strobe_pipe.sv
// Delays the pre-adder load strobe to produce the product and accumulate strobes.
module fir_strobe_pipe
    import fir_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic sum_en,
    output logic prod_en,
    output logic acc_en
);

    logic [PIPE_D-1:0] stage;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage <= '0;
        end else if (restart) begin
            stage <= '0;
        end else begin
            stage <= {stage[PIPE_D-2:0], sum_en};
        end
    end

    assign prod_en = stage[0];
    assign acc_en  = stage[PIPE_D-1];

endmodule

// File: rtl/fir_mac_seq.sv
// Sequencer for the symmetric FIR MAC datapath; all outputs are registered.
// Defining FIR_MAC_SEQ_STATS_EN adds the drop_cnt and last_lat statistics outputs.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int TAPS  = TAPS_DEF,
    parameter int AW    = AW_DEF,
    parameter int NX    = NX_DEF,
    parameter int NSAMP = NSAMP_DEF,
    parameter int YAW   = YAW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           restart,
    output logic           busy,
    output logic           shift_en,
    output logic [AW-1:0]  x_addr,
    output logic           x_zero,
    output logic [AW-1:0]  h_addr,
    output logic [AW-1:0]  lo_idx,
    output logic [AW-1:0]  hi_idx,
    output logic           pair_sel,
    output logic           acc_clr,
    output logic           sum_en,
    output logic           prod_en,
    output logic           acc_en,
    output logic           red_en,
    output logic           y_we,
    output logic [YAW-1:0] y_waddr,
    output logic           frame_done,
    output logic           overrun
`ifdef FIR_MAC_SEQ_STATS_EN
   ,output logic [7:0]     drop_cnt,
    output logic [7:0]     last_lat
`endif
);

    // state | meaning
    // IDLE  | waiting for a sample strobe
    // SHIFT | shift delay line, clear accumulator, advance input address
    // ISSUE | one beat per tap pair, centre tap on the last beat
    // DRAIN | wait for the last product to reach the accumulator
    // RED   | load the saturated result register
    // WRT   | write the result to output RAM
    // FIN   | frame complete, waiting for restart

    localparam int NBL = nb_of(TAPS);

    fir_state_t     state, state_nxt;
    logic [AW-1:0]  beat_nxt, x_addr_nxt;
    logic [YAW-1:0] y_waddr_nxt;
    logic [1:0]     drain_cnt, drain_nxt;
    logic           overrun_nxt, busy_nxt, drop_evt;

    assign drop_evt = start && busy && !restart;
    assign busy_nxt = state_nxt inside {SHIFT, ISSUE, DRAIN, RED, WRT};

    always_comb begin
        state_nxt   = state;
        beat_nxt    = lo_idx;
        drain_nxt   = drain_cnt;
        x_addr_nxt  = x_addr;
        y_waddr_nxt = y_waddr;
        overrun_nxt = overrun || drop_evt;
        case (state)
            IDLE:  if (start && !frame_done) state_nxt = SHIFT;
            SHIFT: begin
                state_nxt = ISSUE;
                beat_nxt  = '0;
                if (x_addr < AW'(NX)) x_addr_nxt = x_addr + AW'(1);
            end
            ISSUE: begin
                if (lo_idx == AW'(NBL - 1)) begin
                    state_nxt = DRAIN;
                    drain_nxt = 2'(PIPE_D - 1);
                end else begin
                    beat_nxt = lo_idx + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd0) state_nxt = RED;
                else drain_nxt = drain_cnt - 2'd1;
            end
            RED:   state_nxt = WRT;
            WRT: begin
                if (y_waddr == YAW'(NSAMP - 1)) begin
                    y_waddr_nxt = '0;
                    state_nxt   = FIN;
                end else begin
                    y_waddr_nxt = y_waddr + YAW'(1);
                    state_nxt   = IDLE;
                end
            end
            FIN:     state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
        // Restart abandons any in-flight sample and outranks a coincident start.
        if (restart) begin
            state_nxt   = IDLE;
            drain_nxt   = '0;
            x_addr_nxt  = '0;
            y_waddr_nxt = '0;
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            x_addr     <= '0;
            y_waddr    <= '0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            shift_en   <= 1'b0;
            acc_clr    <= 1'b0;
            x_zero     <= 1'b0;
            sum_en     <= 1'b0;
            pair_sel   <= 1'b0;
            lo_idx     <= '0;
            h_addr     <= '0;
            hi_idx     <= '0;
            red_en     <= 1'b0;
            y_we       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            x_addr     <= x_addr_nxt;
            y_waddr    <= y_waddr_nxt;
            overrun    <= overrun_nxt;
            busy       <= busy_nxt;
            shift_en   <= (state_nxt == SHIFT);
            acc_clr    <= (state_nxt == SHIFT);
            x_zero     <= (state_nxt == SHIFT) && (x_addr == AW'(NX));
            sum_en     <= (state_nxt == ISSUE);
            pair_sel   <= (state_nxt == ISSUE) && (beat_nxt != AW'(NBL - 1));
            if (state_nxt == ISSUE) begin
                lo_idx <= beat_nxt;
                h_addr <= beat_nxt;
                hi_idx <= AW'(TAPS - 1) - beat_nxt;
            end
            red_en     <= (state_nxt == RED);
            y_we       <= (state_nxt == WRT);
            frame_done <= (state_nxt == FIN);
        end
    end

    fir_strobe_pipe u_strobe_pipe (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .sum_en  (sum_en),
        .prod_en (prod_en),
        .acc_en  (acc_en)
    );

`ifdef FIR_MAC_SEQ_STATS_EN
    logic [7:0] lat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            lat_cnt  <= '0;
            last_lat <= '0;
        end else if (restart) begin
            drop_cnt <= '0;
            lat_cnt  <= '0;
            last_lat <= '0;
        end else begin
            if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (state_nxt == SHIFT) lat_cnt <= 8'd1;
            else if (busy_nxt && lat_cnt != 8'hFF) lat_cnt <= lat_cnt + 8'd1;
            if (state == WRT) last_lat <= lat_cnt;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: per-cycle strobe timing model plus a
// scoreboard of expected output-RAM write addresses.
module tb_fir_mac_seq;
    import fir_pkg::*;

    localparam int TAPS  = 73;
    localparam int AW    = 7;
    localparam int NX    = 100;
    localparam int NSAMP = 172;
    localparam int YAW   = 8;

    logic           clk, reset, start, restart;
    logic           busy, shift_en, x_zero, pair_sel, acc_clr, sum_en, prod_en, acc_en;
    logic           red_en, y_we, frame_done, overrun;
    logic [AW-1:0]  x_addr, h_addr, lo_idx, hi_idx;
    logic [YAW-1:0] y_waddr;
`ifdef FIR_MAC_SEQ_STATS_EN
    logic [7:0]     drop_cnt, last_lat;
`endif

    int   n_chk = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   model_x, model_y, model_drop;
    logic model_ovr;

    fir_mac_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .restart    (restart),
        .busy       (busy),
        .shift_en   (shift_en),
        .x_addr     (x_addr),
        .x_zero     (x_zero),
        .h_addr     (h_addr),
        .lo_idx     (lo_idx),
        .hi_idx     (hi_idx),
        .pair_sel   (pair_sel),
        .acc_clr    (acc_clr),
        .sum_en     (sum_en),
        .prod_en    (prod_en),
        .acc_en     (acc_en),
        .red_en     (red_en),
        .y_we       (y_we),
        .y_waddr    (y_waddr),
        .frame_done (frame_done),
        .overrun    (overrun)
`ifdef FIR_MAC_SEQ_STATS_EN
       ,.drop_cnt   (drop_cnt),
        .last_lat   (last_lat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output-RAM write must match the next queued address.
    always @(negedge clk) begin
        if (reset && y_we) begin
            if (exp_q.size() == 0) check("y_we_unexpected", 32'(y_we), 32'd0);
            else check("y_waddr", 32'(y_waddr), exp_q.pop_front());
        end
    end

    // One sample; cycle c counts from the edge that samples start (c=1 is the first cycle after it).
    task automatic run_sample(input int drop_at);
        logic [10:0] e;
        logic        last;
        last = (model_y == NSAMP - 1);
        exp_q.push_back(model_y);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            start = 1'b0;
            e = {c == 1, c == 1, (c >= 2 && c <= 38), (c >= 3 && c <= 39), (c >= 4 && c <= 40),
                 c == 41, c == 42, (c >= 1 && c <= 42), (c >= 2 && c <= 37),
                 (model_ovr || (drop_at > 0 && c > drop_at)), (c == 43 && last)};
            check("strobes", 32'({shift_en, acc_clr, sum_en, prod_en, acc_en, red_en, y_we,
                                  busy, pair_sel, overrun, frame_done}), 32'(e));
            if (c >= 2 && c <= 38) begin
                check("h_addr", 32'(h_addr), 32'(c - 2));
                check("lo_idx", 32'(lo_idx), 32'(c - 2));
                check("idx_sum", 32'(lo_idx) + 32'(hi_idx), 32'(TAPS - 1));
            end
            if (c == 38) check("centre_hi_idx", 32'(hi_idx), 32'(NB - 1));
            if (c == 1) begin
                check("x_addr_shift", 32'(x_addr), 32'(model_x));
                check("x_zero", 32'(x_zero), 32'(model_x == NX));
            end
            if (c == 2) check("x_addr_next", 32'(x_addr), 32'((model_x < NX) ? model_x + 1 : NX));
            if (c == drop_at) start = 1'b1;
        end
        if (drop_at > 0) begin
            model_ovr = 1'b1;
            if (model_drop < 255) model_drop++;
        end
        if (model_x < NX) model_x++;
        model_y = last ? 0 : model_y + 1;
        check("y_waddr_after", 32'(y_waddr), 32'(model_y));
`ifdef FIR_MAC_SEQ_STATS_EN
        check("last_lat", 32'(last_lat), 32'd42);
        check("drop_cnt", 32'(drop_cnt), 32'(model_drop));
`endif
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
        check("restart_strobes", 32'({busy, frame_done, overrun, shift_en, sum_en, prod_en,
                                      acc_en, red_en, y_we}), 32'd0);
        check("restart_x_addr", 32'(x_addr), 32'd0);
        check("restart_y_waddr", 32'(y_waddr), 32'd0);
`ifdef FIR_MAC_SEQ_STATS_EN
        check("restart_drop_cnt", 32'(drop_cnt), 32'd0);
        check("restart_last_lat", 32'(last_lat), 32'd0);
`endif
        model_x    = 0;
        model_y    = 0;
        model_ovr  = 1'b0;
        model_drop = 0;
    endtask

    initial begin
        int n_wb;
        reset      = 1'b0;
        start      = 1'b0;
        restart    = 1'b0;
        model_x    = 0;
        model_y    = 0;
        model_ovr  = 1'b0;
        model_drop = 0;
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({busy, shift_en, x_zero, pair_sel, acc_clr, sum_en, prod_en,
                                    acc_en, red_en, y_we, frame_done, overrun}), 32'd0);
        check("reset_addrs", 32'({x_addr, h_addr, lo_idx, hi_idx}), 32'd0);
        check("reset_y_waddr", 32'(y_waddr), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single sample, then a sample hit by a start at cycle 10.
        run_sample(0);
        run_sample(10);
        do_restart();

        // Full frame from a clean restart: input address saturation and frame completion.
        for (int k = 0; k < NSAMP; k++) run_sample(0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("fin_ignores_start", 32'({shift_en, busy, overrun, frame_done}), 32'b0001);
        end
        do_restart();

        // Abandon a sample at cycle 20, with a dropped start at cycle 10 beforehand.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            start = (c == 10);
        end
        check("abort_overrun", 32'(overrun), 32'd1);
`ifdef FIR_MAC_SEQ_STATS_EN
        check("abort_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        do_restart();
        n_wb = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (red_en || y_we || busy) n_wb++;
        end
        check("abort_no_writeback", 32'(n_wb), 32'd0);

        // restart and start together: restart wins.
        @(negedge clk);
        start   = 1'b1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        restart = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("restart_beats_start", 32'({shift_en, busy}), 32'd0);
        end

        run_sample(0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
